stride_switch_array: RTL and testbench

STRIDE_SWITCH_ARRAY -- requirements
Module: stride_switch_array

---
 rtl/stride_switch_array_if.sv | 24 ++
 rtl/stride_switch_array.sv | 87 ++++++++
 tb/tb_stride_switch_array.sv | 138 +++++++++++++
 3 files changed

// File: rtl/stride_switch_array_if.sv
// Beat stream bundle for stride_switch_array: frame control, input beat and switched output.
// The master drives start/mode/in_*; the slave (the switch) drives out_* and frame_done.
interface stride_switch_array_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4
);
    logic                        start;
    logic [1:0]                  mode;
    logic                        in_valid;
    logic [LANES*DATA_WIDTH-1:0] in_data;
    logic                        out_valid;
    logic [LANES*DATA_WIDTH-1:0] out_data;
    logic                        frame_done;

    modport master (
        output start, mode, in_valid, in_data,
        input  out_valid, out_data, frame_done
    );

    modport slave (
        input  start, mode, in_valid, in_data,
        output out_valid, out_data, frame_done
    );
endinterface

// File: rtl/stride_switch_array.sv
// Pairwise lane switch: each lane pair is straight or crossed per beat,
// driven by a frame-aligned mode and beat counter; one-cycle registered output.
module stride_switch_array #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int PERIOD_LOG = 3
) (
    input logic                  clk,
    input logic                  rst,
    stride_switch_array_if.slave bus
);
    localparam int CW = PERIOD_LOG + 1;
    localparam int W  = LANES * DATA_WIDTH;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    act_q, act_d;
    logic          vld_q;
    logic          done_q;
    logic [W-1:0]  dat_q;

    logic [CW-1:0] eff_cnt;
    logic [1:0]    eff_mode;
    logic          ctrl;
    logic [W-1:0]  sw_data;

    // The beat sees the mode it will load: start forces beat 0, and an
    // accepted beat at cnt=0 opens a new frame with the current mode input.
    always_comb begin
        eff_cnt  = bus.start ? '0 : cnt_q;
        eff_mode = act_q;
        if (bus.start || (bus.in_valid && cnt_q == '0))
            eff_mode = bus.mode;
    end

    always_comb begin
        ctrl = 1'b0;
        unique case (eff_mode)
            2'd0: ctrl = 1'b0;
            2'd1: ctrl = 1'b1;
            2'd2: ctrl = eff_cnt[PERIOD_LOG];
            2'd3: ctrl = ~eff_cnt[PERIOD_LOG];
            default: ctrl = 1'b0;
        endcase
    end

    for (genvar k = 0; k < LANES / 2; k++) begin : g_pair
        localparam int LO = (2 * k) * DATA_WIDTH;
        localparam int HI = (2 * k + 1) * DATA_WIDTH;
        assign sw_data[LO +: DATA_WIDTH] =
            ctrl ? bus.in_data[HI +: DATA_WIDTH] : bus.in_data[LO +: DATA_WIDTH];
        assign sw_data[HI +: DATA_WIDTH] =
            ctrl ? bus.in_data[LO +: DATA_WIDTH] : bus.in_data[HI +: DATA_WIDTH];
    end

    always_comb begin
        cnt_d = cnt_q;
        act_d = act_q;
        if (bus.start) begin
            act_d = bus.mode;
            cnt_d = bus.in_valid ? CW'(1) : '0;
        end else if (bus.in_valid) begin
            act_d = eff_mode;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            act_q  <= 2'd0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            vld_q  <= bus.in_valid;
            done_q <= bus.in_valid && (eff_cnt == {CW{1'b1}});
            if (bus.in_valid)
                dat_q <= sw_data;
        end
    end

    assign bus.out_valid  = vld_q;
    assign bus.out_data   = dat_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_stride_switch_array.sv
// Directed vector bench for stride_switch_array (LANES=4, DATA_WIDTH=32, PERIOD_LOG=1).
// Each record is one cycle of inputs plus the outputs expected after that edge.
module tb_stride_switch_array;
    localparam int DW = 32;
    localparam int LN = 4;
    localparam int PL = 1;
    localparam int W  = DW * LN;

    typedef struct {
        logic         rst;
        logic         start;
        logic [1:0]   mode;
        logic         vld;
        logic [W-1:0] data;
        logic         e_vld;
        logic [W-1:0] e_data;
        logic         e_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];

    stride_switch_array_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

    stride_switch_array #(
        .DATA_WIDTH(DW),
        .LANES     (LN),
        .PERIOD_LOG(PL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(int n);
        logic [W-1:0] d;
        for (int i = 0; i < LN; i++)
            d[i*DW +: DW] = 32'hA000_0000 + n * 16 + i;
        return d;
    endfunction

    function automatic logic [W-1:0] sw(logic [W-1:0] d);
        return {d[95:64], d[127:96], d[31:0], d[63:32]};
    endfunction

    task automatic add(input logic r, input logic s, input logic [1:0] m,
                       input logic v, input logic [W-1:0] d,
                       input logic ev, input logic [W-1:0] ed,
                       input logic edn);
        vec_t t;
        t.rst = r; t.start = s; t.mode = m; t.vld = v; t.data = d;
        t.e_vld = ev; t.e_data = ed; t.e_done = edn;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        logic [W-1:0] z;
        z = '0;
        // reset with beats presented: discarded
        add(1, 0, 0, 1, mk(1), 0, z, 0);
        add(1, 0, 0, 1, mk(2), 0, z, 0);
        add(0, 0, 0, 0, mk(3), 0, z, 0);
        // periodic mode, 8 beats back to back
        add(0, 1, 2, 0, mk(4), 0, z, 0);
        for (int n = 0; n < 8; n++)
            add(0, 0, 2, 1, mk(10 + n), 1,
                (n % 4 >= 2) ? sw(mk(10 + n)) : mk(10 + n), n % 4 == 3);
        // bubbles: 1,0,1,0,1,1
        add(0, 0, 2, 1, mk(20), 1, mk(20), 0);
        add(0, 0, 2, 0, mk(99), 0, mk(20), 0);
        add(0, 0, 2, 1, mk(21), 1, mk(21), 0);
        add(0, 0, 2, 0, mk(98), 0, mk(21), 0);
        add(0, 0, 2, 1, mk(22), 1, sw(mk(22)), 0);
        add(0, 0, 2, 1, mk(23), 1, sw(mk(23)), 1);
        // mode 1 frame, mode input drops to 0 at cnt=2
        add(0, 0, 1, 1, mk(30), 1, sw(mk(30)), 0);
        add(0, 0, 1, 1, mk(31), 1, sw(mk(31)), 0);
        add(0, 0, 0, 1, mk(32), 1, sw(mk(32)), 0);
        add(0, 0, 0, 1, mk(33), 1, sw(mk(33)), 1);
        add(0, 0, 0, 1, mk(34), 1, mk(34), 0);
        add(0, 0, 0, 1, mk(35), 1, mk(35), 0);
        // start+beat at cnt=2, mode 3; later mode input ignored mid-frame
        add(0, 1, 3, 1, mk(40), 1, sw(mk(40)), 0);
        add(0, 0, 0, 1, mk(41), 1, sw(mk(41)), 0);
        add(0, 0, 0, 1, mk(42), 1, mk(42), 0);
        add(0, 0, 0, 1, mk(43), 1, mk(43), 1);
        // reset mid-frame in mode 1 at cnt=3
        add(0, 1, 1, 0, mk(50), 0, mk(43), 0);
        add(0, 0, 1, 1, mk(51), 1, sw(mk(51)), 0);
        add(0, 0, 1, 1, mk(52), 1, sw(mk(52)), 0);
        add(0, 0, 1, 1, mk(53), 1, sw(mk(53)), 0);
        add(1, 0, 1, 1, mk(54), 0, z, 0);
        for (int n = 0; n < 4; n++)
            add(0, 0, 0, 1, mk(60 + n), 1, mk(60 + n), n == 3);

        bus.start = 0; bus.mode = 0; bus.in_valid = 0; bus.in_data = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            bus.start    = vecs[i].start;
            bus.mode     = vecs[i].mode;
            bus.in_valid = vecs[i].vld;
            bus.in_data  = vecs[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), W'(bus.out_valid), W'(vecs[i].e_vld));
            chk($sformatf("v%0d out_data", i), bus.out_data, vecs[i].e_data);
            chk($sformatf("v%0d frame_done", i), W'(bus.frame_done), W'(vecs[i].e_done));
        end

        // idle tail: output holds, valid and done drop
        @(negedge clk);
        bus.in_valid = 0;
        bus.start = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle out_valid", W'(bus.out_valid), W'(1'b0));
        chk("idle out_data", bus.out_data, mk(63));
        chk("idle frame_done", W'(bus.frame_done), W'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
